// File: rtl/exc_ctrl.sv
// Exception/interrupt commit controller: detects memory-stage events, commits them to CP0, flushes and redirects.
// Latency: COMMIT one cycle after detect; flush_o high FLUSH_CYC cycles. Optional timer interrupt via EXC_CTRL_TIMER_INT_EN.
// Backpressure: stall_i blocks detection; inputs are ignored while busy_o is high (nothing is queued).
module exc_ctrl #(
  parameter int          FLUSH_CYC = 2,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [6:0]  exc_i,
  input  logic        eret_i,
  input  logic [31:0] pc_i,
  input  logic        dslot_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        timer_int_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_pc_o,
  output logic [31:0] bad_addr_o,
  output logic        dslot_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] code_q, pc_q, bad_q, npc_q;
  logic        ds_q;
  logic [7:0]  ip;
  logic        int_pend, detect;
  logic [31:0] code_d, bad_d;
  logic        unused_ok;

`ifdef EXC_CTRL_TIMER_INT_EN
  assign ip = {cause_i[15] | timer_int_i, cause_i[14:8]};
  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
  assign ip = cause_i[15:8];
  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0], timer_int_i};
`endif

  assign int_pend = status_i[0] & ~status_i[1] & (|(ip & status_i[15:8]));
  assign detect   = mem_valid_i & ~stall_i & (int_pend | (|exc_i) | eret_i);

  // Priority encoder: interrupt first, ERET last
  always_comb begin
    code_d = 32'h0;
    bad_d  = 32'h0;
    if (int_pend)      code_d = 32'h1;
    else if (exc_i[0]) begin code_d = 32'h4; bad_d = pc_i; end
    else if (exc_i[1]) code_d = 32'ha;
    else if (exc_i[2]) code_d = 32'hc;
    else if (exc_i[3]) code_d = 32'h8;
    else if (exc_i[4]) code_d = 32'h9;
    else if (exc_i[5]) begin code_d = 32'h4; bad_d = daddr_i; end
    else if (exc_i[6]) begin code_d = 32'h5; bad_d = daddr_i; end
    else if (eret_i)   code_d = 32'he;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (detect) state_nxt = COMMIT;
      COMMIT:  state_nxt = (FLUSH_CYC > 1) ? FLUSH : IDLE;
      FLUSH:   if (cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Event capture and FLUSH down-counter (saturates at zero)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= 32'h0;
      pc_q   <= 32'h0;
      bad_q  <= 32'h0;
      npc_q  <= 32'h0;
      ds_q   <= 1'b0;
      cnt    <= 4'd0;
    end else if (state == IDLE && detect) begin
      code_q <= code_d;
      pc_q   <= pc_i;
      bad_q  <= bad_d;
      npc_q  <= (code_d == 32'he) ? epc_i : EXC_VEC;
      ds_q   <= dslot_i;
      cnt    <= 4'(FLUSH_CYC - 1);
    end else if (state == FLUSH && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    excepttype_o = 32'h0;
    cur_pc_o     = 32'h0;
    bad_addr_o   = 32'h0;
    dslot_o      = 1'b0;
    flush_o      = (state != IDLE);
    busy_o       = (state != IDLE);
    newpc_o      = (state != IDLE) ? npc_q : 32'h0;
    if (state == COMMIT) begin
      excepttype_o = code_q;
      cur_pc_o     = pc_q;
      bad_addr_o   = bad_q;
      dslot_o      = ds_q;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: two instances (FLUSH_CYC 2 and 3) checked each cycle against a cycle-indexed event model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, stall_i, eret_i, dslot_i, timer_int_i;
  logic [6:0]  exc_i;
  logic [31:0] pc_i, daddr_i, status_i, cause_i, epc_i;

  logic [31:0] et[2], cp[2], ba[2], np[2];
  logic        ds[2], fl[2], bz[2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.FLUSH_CYC(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .stall_i(stall_i), .exc_i(exc_i),
    .eret_i(eret_i), .pc_i(pc_i), .dslot_i(dslot_i), .daddr_i(daddr_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i), .excepttype_o(et[0]),
    .cur_pc_o(cp[0]), .bad_addr_o(ba[0]), .dslot_o(ds[0]), .flush_o(fl[0]), .newpc_o(np[0]),
    .busy_o(bz[0]));

  exc_ctrl #(.FLUSH_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .stall_i(stall_i), .exc_i(exc_i),
    .eret_i(eret_i), .pc_i(pc_i), .dslot_i(dslot_i), .daddr_i(daddr_i), .status_i(status_i),
    .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i), .excepttype_o(et[1]),
    .cur_pc_o(cp[1]), .bad_addr_o(ba[1]), .dslot_o(ds[1]), .flush_o(fl[1]), .newpc_o(np[1]),
    .busy_o(bz[1]));

  function automatic int fcyc(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  // Event code from the architectural priority rules
  function automatic logic [31:0] model_code(logic [31:0] st, logic [31:0] ca, logic [6:0] ex,
                                             logic er, logic tm);
    logic [31:0] c;
    c = ca;
`ifdef EXC_CTRL_TIMER_INT_EN
    if (tm) c[15] = 1'b1;
`else
    if (tm) c = ca;
`endif
    if (st[0] && !st[1] && ((c[15:8] & st[15:8]) != 8'h0)) return 32'h1;
    if (ex[0]) return 32'h4;
    if (ex[1]) return 32'ha;
    if (ex[2]) return 32'hc;
    if (ex[3]) return 32'h8;
    if (ex[4]) return 32'h9;
    if (ex[5]) return 32'h4;
    if (ex[6]) return 32'h5;
    if (er)    return 32'he;
    return 32'h0;
  endfunction

  logic [31:0] m_code, m_bad;
  always_comb begin
    m_code = model_code(status_i, cause_i, exc_i, eret_i, timer_int_i);
    m_bad  = 32'h0;
    if (m_code != 32'h1) begin
      if (exc_i[0])                      m_bad = pc_i;
      else if (exc_i[4:1] != 4'h0)       m_bad = 32'h0;
      else if (exc_i[5] || exc_i[6])     m_bad = daddr_i;
    end
  end

  // Model: cycle number of the commit and of the last busy cycle per instance
  int          cyc = 0;
  int          commit_cyc[2] = '{-1, -1};
  int          busy_end[2]   = '{-1, -1};
  logic [31:0] exp_code[2], exp_pc[2], exp_bad[2], exp_npc[2];
  logic        exp_ds[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        commit_cyc[i] <= -1;
        busy_end[i]   <= -1;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (mem_valid_i && !stall_i && m_code != 32'h0 && cyc > busy_end[i]) begin
          commit_cyc[i] <= cyc + 1;
          busy_end[i]   <= cyc + fcyc(i);
          exp_code[i]   <= m_code;
          exp_pc[i]     <= pc_i;
          exp_bad[i]    <= m_bad;
          exp_ds[i]     <= dslot_i;
          exp_npc[i]    <= (m_code == 32'he) ? epc_i : 32'hBFC00380;
        end
      end
    end
  end

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h", name, inst, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("excepttype", i, et[i], (cyc == commit_cyc[i]) ? exp_code[i] : 32'h0);
      chk("cur_pc",     i, cp[i], (cyc == commit_cyc[i]) ? exp_pc[i]   : 32'h0);
      chk("bad_addr",   i, ba[i], (cyc == commit_cyc[i]) ? exp_bad[i]  : 32'h0);
      chk("dslot",      i, {31'h0, ds[i]}, (cyc == commit_cyc[i]) ? {31'h0, exp_ds[i]} : 32'h0);
      chk("flush",      i, {31'h0, fl[i]},
          {31'h0, (cyc >= commit_cyc[i] && cyc <= busy_end[i])});
      chk("busy",       i, {31'h0, bz[i]},
          {31'h0, (cyc >= commit_cyc[i] && cyc <= busy_end[i])});
      chk("newpc",      i, np[i],
          (cyc >= commit_cyc[i] && cyc <= busy_end[i]) ? exp_npc[i] : 32'h0);
    end
  end

  task automatic idle_in();
    mem_valid_i = 1'b0; stall_i = 1'b0; exc_i = 7'h0; eret_i = 1'b0; pc_i = 32'h0;
    dslot_i = 1'b0; daddr_i = 32'h0; status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0;
    timer_int_i = 1'b0;
  endtask

  task automatic settle();
    idle_in();
    repeat (5) @(negedge clk);
  endtask

  logic [6:0]  tbl_exc[6]  = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h40, 7'h60};
  logic [31:0] tbl_code[6] = '{32'ha, 32'hc, 32'h8, 32'h9, 32'h5, 32'h4};

  initial begin
    rst = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);

    // Sys taken on the first edge after reset release
    rst = 1'b1; mem_valid_i = 1'b1; exc_i = 7'h08; pc_i = 32'h80001000;
    @(negedge clk);
    chk("sys_code", 0, et[0], 32'h8);
    chk("sys_pc", 0, cp[0], 32'h80001000);
    chk("sys_flush", 0, {31'h0, fl[0]}, 32'h1);
    chk("sys_newpc", 0, np[0], 32'hBFC00380);
    idle_in();
    @(negedge clk);
    chk("sys_code_clr", 0, et[0], 32'h0);
    chk("sys_flush2", 0, {31'h0, fl[0]}, 32'h1);
    @(negedge clk);
    chk("sys_flush_end", 0, {31'h0, fl[0]}, 32'h0);
    chk("sys_newpc_end", 0, np[0], 32'h0);
    settle();

    mem_valid_i = 1'b1; exc_i = 7'h20; daddr_i = 32'h3; dslot_i = 1'b1; pc_i = 32'h80000010;
    @(negedge clk);
    chk("ladel_code", 0, et[0], 32'h4);
    chk("ladel_bad", 0, ba[0], 32'h3);
    chk("ladel_dslot", 0, {31'h0, ds[0]}, 32'h1);
    settle();

    mem_valid_i = 1'b1; eret_i = 1'b1; status_i = 32'h401; cause_i = 32'h400; epc_i = 32'h80002000;
    @(negedge clk);
    chk("int_over_eret", 0, et[0], 32'h1);
    chk("int_newpc", 0, np[0], 32'hBFC00380);
    settle();

    mem_valid_i = 1'b1; eret_i = 1'b1; epc_i = 32'h80002000;
    @(negedge clk);
    chk("eret_code", 0, et[0], 32'he);
    chk("eret_newpc", 0, np[0], 32'h80002000);
    settle();

    // EXL set masks the pending interrupt
    mem_valid_i = 1'b1; eret_i = 1'b1; status_i = 32'h403; cause_i = 32'h400; epc_i = 32'h80003000;
    @(negedge clk);
    chk("exl_mask", 0, et[0], 32'he);
    settle();

    mem_valid_i = 1'b1; exc_i = 7'h04; stall_i = 1'b1; pc_i = 32'h80000100;
    repeat (3) begin
      @(negedge clk);
      chk("stall_block", 0, {31'h0, bz[0]}, 32'h0);
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("stall_ov", 0, et[0], 32'hc);
    settle();

    mem_valid_i = 1'b0; exc_i = 7'h7f; status_i = 32'h401; cause_i = 32'h400;
    repeat (3) begin
      @(negedge clk);
      chk("bubble", 0, {31'h0, bz[0]}, 32'h0);
    end
    settle();

    // Held Bp: ignored in last FLUSH cycle, retaken in first IDLE cycle
    mem_valid_i = 1'b1; exc_i = 7'h10; pc_i = 32'h80000200;
    @(negedge clk);
    chk("b2b_first", 0, et[0], 32'h9);
    @(negedge clk);
    chk("b2b_flush", 0, et[0], 32'h0);
    @(negedge clk);
    chk("b2b_idle", 0, {31'h0, bz[0]}, 32'h0);
    @(negedge clk);
    chk("b2b_second", 0, et[0], 32'h9);
    repeat (6) @(negedge clk);
    settle();

    mem_valid_i = 1'b1; exc_i = 7'h7f; eret_i = 1'b1; pc_i = 32'h80004000; daddr_i = 32'h1234;
    @(negedge clk);
    chk("all_code", 0, et[0], 32'h4);
    chk("all_bad", 0, ba[0], 32'h80004000);
    settle();

    for (int k = 0; k < 6; k++) begin
      mem_valid_i = 1'b1; exc_i = tbl_exc[k]; pc_i = 32'h80006000 + 32'(k * 4); daddr_i = 32'h5678;
      @(negedge clk);
      chk("table_code", 0, et[0], tbl_code[k]);
      settle();
    end

    // Reset asserted mid-FLUSH
    mem_valid_i = 1'b1; exc_i = 7'h08; pc_i = 32'h80005000;
    @(negedge clk);
    idle_in();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_flush", 0, {31'h0, fl[0]}, 32'h0);
    chk("rst_busy", 0, {31'h0, bz[0]}, 32'h0);
    chk("rst_newpc", 0, np[0], 32'h0);
    chk("rst_busy", 1, {31'h0, bz[1]}, 32'h0);
    @(negedge clk);
    rst = 1'b1; mem_valid_i = 1'b1; exc_i = 7'h04;
    @(negedge clk);
    chk("post_rst_ov", 0, et[0], 32'hc);
    settle();

    mem_valid_i = 1'b1; status_i = 32'h8001; timer_int_i = 1'b1;
    @(negedge clk);
`ifdef EXC_CTRL_TIMER_INT_EN
    chk("timer_int", 0, et[0], 32'h1);
`else
    chk("timer_ignored", 0, {31'h0, bz[0]}, 32'h0);
`endif
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2: number of cycles flush_o is held per event (legal 1..15).
REQ-002 SHALL have parameter EXC_VEC, default 32'hBFC00380: exception handler entry address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid_i  input  1  a real instruction occupies the memory stage.
REQ-006 SHALL have port stall_i  input  1  memory stage stalled; no event may be taken.
REQ-007 SHALL have port exc_i  input  7  flags: [0] fetch AdEL, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] load AdEL, [6] AdES.
REQ-008 SHALL have port eret_i  input  1  ERET in memory stage.
REQ-009 SHALL have port pc_i  input  32  memory-stage instruction address.
REQ-010 SHALL have port dslot_i  input  1  memory-stage instruction is in a delay slot.
REQ-011 SHALL have port daddr_i  input  32  data address of the memory-stage access.
REQ-012 SHALL have ports status_i, cause_i, epc_i  input  32 each  current CP0 Status/Cause/EPC.
REQ-013 SHALL have port timer_int_i  input  1  CP0 timer interrupt.
REQ-014 SHALL have ports excepttype_o, cur_pc_o, bad_addr_o  output  32 each  and dslot_o  output  1  CP0 exception-commit bundle.
REQ-015 SHALL have ports flush_o  output  1  and newpc_o  output  32  pipeline flush and redirect target.
REQ-016 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> COMMIT -> FLUSH -> IDLE; FLUSH is skipped when FLUSH_CYC=1.
REQ-018 Event detect: in IDLE, mem_valid_i=1, stall_i=0, and (int pending, any exc_i bit, or eret_i).
REQ-019 Int pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
REQ-020 Priority, highest first: interrupt(0x1), fetch AdEL(0x4), RI(0xa), Ov(0xc), Sys(0x8), Bp(0x9), load AdEL(0x4), AdES(0x5), ERET(0xe).
REQ-021 On detect, next edge SHALL enter COMMIT with all outputs registered from the detect-cycle inputs: excepttype_o=code, cur_pc_o=pc_i, dslot_o=dslot_i.
REQ-022 bad_addr_o SHALL be pc_i for fetch AdEL, daddr_i for load AdEL/AdES, else 0.
REQ-023 newpc_o SHALL be epc_i for ERET, else EXC_VEC; it is held valid through COMMIT and FLUSH.
REQ-024 excepttype_o SHALL be nonzero in COMMIT only (exactly one cycle per event), 0 otherwise.
REQ-025 flush_o SHALL be high for exactly FLUSH_CYC consecutive cycles starting at COMMIT.
REQ-026 Outside IDLE, all detect inputs SHALL be ignored; no event is queued.
REQ-027 stall_i=1 SHALL block detection entirely; an event is taken on the first unstalled cycle.
REQ-028 Detect is gated by mem_valid_i: bubbles never take interrupts.
REQ-029 Back-to-back events SHALL be possible: detect in the last FLUSH cycle is ignored; detect in the first IDLE cycle is accepted.
REQ-030 A FLUSH down-counter of 4 bits SHALL count FLUSH_CYC-1 cycles; no wrap beyond zero.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and all outputs to 0, including mid-COMMIT/FLUSH; newpc_o=0.
REQ-032 After reset release, the first rising edge SHALL be able to detect an event.

Configuration
REQ-033 Macro EXC_CTRL_TIMER_INT_EN: when defined, timer_int_i is ORed into cause_i[15] before REQ-019 masking; when undefined, timer_int_i is ignored.

Verification
REQ-034 Sys at pc 0x80001000, dslot=0, FLUSH_CYC=2 -> COMMIT: excepttype 0x8, cur_pc 0x80001000; flush 2 cycles; newpc 0xBFC00380.
REQ-035 Load AdEL with daddr 0x00000003, dslot=1 -> excepttype 0x4, bad_addr 0x00000003, dslot_o=1.
REQ-036 eret_i plus status=0x00000401, cause=0x00000400 -> excepttype 0x1 (interrupt beats ERET).
REQ-037 eret_i with epc_i=0x80002000, no interrupt -> excepttype 0xe, newpc 0x80002000.
REQ-038 Ov with stall_i=1 for 3 cycles then 0 -> single COMMIT on the cycle after stall drops, exactly one excepttype pulse.
REQ-039 rst=0 asserted during FLUSH -> flush_o, busy_o, newpc_o read 0 immediately; with macro defined, timer_int_i=1, status=0x00008001 -> excepttype 0x1.
